program_loader: RTL and testbench

- Upstream stage of the 3-bit CPU: streams a program into the CPU's 8x3 instruction memory through a valid/ready input and a memory write port.
- Holds the CPU in reset while loading and releases it when the image is complete.
- Pads short programs with NOP-equivalent fill words so the CPU never executes stale memory.

---
 rtl/cpu_pkg.sv | 29 ++
 rtl/loader_checksum.sv | 28 ++
 rtl/program_loader.sv | 172 +++++++++++++++++
 tb/tb_program_loader.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared constants and types for the 3-bit CPU and its program loader.
// ADDR_W must equal $clog2(DEPTH).
package cpu_pkg;

  localparam int unsigned WIDTH  = 3;
  localparam int unsigned DEPTH  = 8;
  localparam int unsigned ADDR_W = 3;

  // Opcodes occupy the upper two bits of an instruction word.
  localparam logic [1:0] OpLoad  = 2'b00;
  localparam logic [1:0] OpAdd   = 2'b01;
  localparam logic [1:0] OpSub   = 2'b10;
  localparam logic [1:0] OpStore = 2'b11;

  // Pad word is LOAD 0, harmless if the CPU ever executes it.
  localparam logic [WIDTH-1:0] FILL_WORD = {OpLoad, 1'b0};

  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(DEPTH - 1);

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StPad,
    StRelease,
    StRun,
    StError
  } loader_state_e;

endpackage

// File: rtl/loader_checksum.sv
// XOR accumulator over accepted program words; match compares the running
// value against the checksum beat presented on check.
module loader_checksum
  import cpu_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             enable,
  input  logic [WIDTH-1:0] data,
  input  logic [WIDTH-1:0] check,
  output logic             match
);

  logic [WIDTH-1:0] acc_q;

  // Running XOR, cleared at the start of every load.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      acc_q <= '0;
    end else if (enable) begin
      acc_q <= acc_q ^ data;
    end
  end

  assign match = (acc_q == check);

endmodule

// File: rtl/program_loader.sv
// Streams a program into the CPU instruction memory, pads short images with
// FILL_WORD and holds the CPU in reset until the image is complete.
// Optional checksum beat: define PROGRAM_LOADER_CHECKSUM_EN.
module program_loader
  import cpu_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  in_data,
  input  logic              in_last,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [WIDTH-1:0]  imem_wdata,
  output logic              cpu_reset,
  output logic              busy,
  output logic              done,
  output logic              error
);

`ifdef PROGRAM_LOADER_CHECKSUM_EN
  localparam bit CkEn = 1'b1;
`else
  localparam bit CkEn = 1'b0;
`endif

  loader_state_e     state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              we_d;
  logic [ADDR_W-1:0] addr_d;
  logic [WIDTH-1:0]  wdata_d;

  logic accept;
  logic launch;
  logic last_addr;
  logic ck_beat;  // accepted beat is a checksum, not a program word
  logic ck_ok;
  logic ck_full;  // all DEPTH program words already received

  assign accept    = in_valid && in_ready;
  assign launch    = start && (state_q == StIdle || state_q == StRun || state_q == StError);
  assign last_addr = (cnt_q == LastAddr);

`ifdef PROGRAM_LOADER_CHECKSUM_EN
  logic full_q;

  assign ck_beat = in_last || full_q;
  assign ck_full = full_q;

  // Counter saturates at DEPTH-1, so a flag remembers the last word landed.
  always_ff @(posedge clk) begin
    if (reset || launch) begin
      full_q <= 1'b0;
    end else if (accept && !ck_beat && last_addr) begin
      full_q <= 1'b1;
    end
  end

  loader_checksum u_checksum (
    .clk    (clk),
    .reset  (reset),
    .clear  (launch),
    .enable (accept && !ck_beat),
    .data   (in_data),
    .check  (in_data),
    .match  (ck_ok)
  );
`else
  assign ck_beat = 1'b0;
  assign ck_ok   = 1'b1;
  assign ck_full = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle, StRun, StError: begin
        if (start) state_d = StLoad;
      end
      StLoad: begin
        if (accept) begin
          if (ck_beat) begin
            if (!ck_ok)       state_d = StError;
            else if (ck_full) state_d = StRelease;
            else              state_d = StPad;
          end else if (last_addr && !CkEn) begin
            state_d = StRelease;
          end else if (in_last && !CkEn) begin
            state_d = StPad;
          end
        end
      end
      StPad: begin
        if (last_addr) state_d = StRelease;
      end
      StRelease: state_d = StRun;
      default:   state_d = StIdle;
    endcase
  end

  // Write-port and counter next values; the final write lands in the RELEASE cycle.
  always_comb begin
    cnt_d   = cnt_q;
    we_d    = 1'b0;
    addr_d  = imem_addr;
    wdata_d = imem_wdata;
    if (launch) begin
      cnt_d = '0;
    end else if (state_q == StLoad && accept && !ck_beat) begin
      we_d    = 1'b1;
      addr_d  = cnt_q;
      wdata_d = in_data;
      if (!last_addr) cnt_d = cnt_q + 1'b1;
    end else if (state_q == StPad) begin
      we_d    = 1'b1;
      addr_d  = cnt_q;
      wdata_d = FILL_WORD;
      if (!last_addr) cnt_d = cnt_q + 1'b1;
    end
  end

  // Counter and registered memory write port.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q      <= '0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
    end else begin
      cnt_q      <= cnt_d;
      imem_we    <= we_d;
      imem_addr  <= addr_d;
      imem_wdata <= wdata_d;
    end
  end

  // State-decoded outputs.
  always_comb begin
    in_ready  = 1'b0;
    cpu_reset = 1'b1;
    busy      = 1'b0;
    done      = 1'b0;
    error     = 1'b0;
    unique case (state_q)
      StLoad: begin
        in_ready = 1'b1;
        busy     = 1'b1;
      end
      StPad:     busy = 1'b1;
      StRelease: begin
        busy = 1'b1;
        done = 1'b1;
      end
      StRun:     cpu_reset = 1'b0;
      StError:   error = CkEn;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_program_loader.sv
// Randomized self-checking bench for program_loader. Follows the build's
// PROGRAM_LOADER_CHECKSUM_EN setting.
module tb_program_loader;

`ifdef PROGRAM_LOADER_CHECKSUM_EN
  localparam bit CK = 1'b1;
`else
  localparam bit CK = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset, start, in_valid, in_ready, in_last;
  logic       imem_we, cpu_reset, busy, done, error;
  logic [2:0] in_data, imem_addr, imem_wdata;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  // Observed writes as (addr << 3) | data, with the cycle they were seen.
  int   wr_q[$];
  int   wr_cyc[$];
  int   done_cnt = 0;
  bit   rel_seen = 1'b0;
  logic rel_cpu_reset = 1'b1;
  logic prev_done = 1'b0;

  always #5 clk = ~clk;

  program_loader dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_last    (in_last),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .cpu_reset  (cpu_reset),
    .busy       (busy),
    .done       (done),
    .error      (error)
  );

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (imem_we === 1'b1) begin
      wr_q.push_back(int'({imem_addr, imem_wdata}));
      wr_cyc.push_back(cyc);
    end
    if (prev_done === 1'b1) begin
      rel_seen      = 1'b1;
      rel_cpu_reset = cpu_reset;
    end
    if (done === 1'b1) done_cnt++;
    prev_done = done;
  end

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_we"},        int'(imem_we),    0);
    check({tag, "_addr"},      int'(imem_addr),  0);
    check({tag, "_wdata"},     int'(imem_wdata), 0);
    check({tag, "_cpu_reset"}, int'(cpu_reset),  1);
    check({tag, "_ready"},     int'(in_ready),   0);
    check({tag, "_busy"},      int'(busy),       0);
    check({tag, "_done"},      int'(done),       0);
    check({tag, "_error"},     int'(error),      0);
  endtask

  // Caller is at posedge+1; returns at posedge+1.
  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("start_cpu_reset", int'(cpu_reset), 1);
    check("start_ready",     int'(in_ready),   1);
    check("start_error",     int'(error),      0);
  endtask

  task automatic send_beat(input logic [2:0] d, input logic last, input bit is_ck,
                           input int idx, input bit gap);
    bit acc = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    for (int t = 0; t < 20 && !acc; t++) begin
      @(negedge clk);
      acc = (in_ready === 1'b1);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    check("accept", int'(acc), 1);
    if (acc) begin
      check("we_after_accept", int'(imem_we), int'(!is_ck));
      if (!is_ck) begin
        check("addr", int'(imem_addr), idx);
        check("wdata", int'(imem_wdata), int'(d));
      end
    end
    if (gap) begin
      @(posedge clk); #1;
      check("we_in_gap", int'(imem_we), 0);
    end
  endtask

  // gap_mode: 0 back-to-back, 1 idle cycle after every beat, 2 random idles.
  task automatic run_load(input logic [2:0] w[8], input int n, input int gap_mode,
                          input bit bad);
    logic [2:0] ck = 3'b000;
    logic       last;
    bit         gap;
    bit         got = 1'b0;
    int         exp;
    wr_q.delete();
    wr_cyc.delete();
    done_cnt = 0;
    rel_seen = 1'b0;
    pulse_start();
    for (int i = 0; i < n; i++) begin
      ck ^= w[i];
      if (CK || i != n - 1) last = 1'b0;
      else if (n < 8)       last = 1'b1;
      else                  last = 1'($urandom_range(0, 1));
      if (i == n - 1)         gap = 1'b0;
      else if (gap_mode == 1) gap = 1'b1;
      else if (gap_mode == 2) gap = 1'($urandom_range(0, 1));
      else                    gap = 1'b0;
      send_beat(w[i], last, 1'b0, i, gap);
    end
    if (CK) begin
      if (bad) ck = ck ^ 3'($urandom_range(1, 7));
      send_beat(ck, 1'b1, 1'b1, 0, 1'b0);
    end
    if (bad) begin
      repeat (12) @(posedge clk);
      #1;
      check("err_flag",      int'(error),     1);
      check("err_cpu_reset", int'(cpu_reset), 1);
      check("err_ready",     int'(in_ready),  0);
      check("err_no_done",   done_cnt,        0);
      check("err_wr_count",  wr_q.size(),     n);
    end else begin
      for (int t = 0; t < 40 && !got; t++) begin
        @(posedge clk); #1;
        got = rel_seen;
      end
      check("done_seen",     int'(got),           1);
      check("done_once",     done_cnt,            1);
      check("run_cpu_reset", int'(rel_cpu_reset), 0);
      check("wr_count",      wr_q.size(),         8);
      for (int i = 0; i < 8 && i < wr_q.size(); i++) begin
        exp = (i << 3) | (i < n ? int'(w[i]) : 0);
        check("wr_word", wr_q[i], exp);
        if (i > n) check("pad_cycle", wr_cyc[i] - wr_cyc[i-1], 1);
      end
    end
  endtask

  initial begin
    logic [2:0] w[8];
    reset    = 1'b1;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = 3'b000;
    in_last  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    check_reset_values("por");

    // Full program, back-to-back.
    w = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0};
    run_load(w, 8, 0, 1'b0);

    // Short program padded to depth; also a reload from RUN.
    w = '{3'd6, 3'd2, 3'd5, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0};
    run_load(w, 3, 0, 1'b0);

    // Valid toggling every other cycle.
    w = '{3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd7};
    run_load(w, 8, 1, 1'b0);

    // Reset after four accepted words abandons the load.
    pulse_start();
    for (int i = 0; i < 4; i++) send_beat(3'(i + 3), 1'b0, 1'b0, i, 1'b0);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check_reset_values("midload");
    w = '{3'd5, 3'd1, 3'd4, 3'd2, 3'd0, 3'd0, 3'd0, 3'd0};
    run_load(w, 4, 0, 1'b0);

`ifdef PROGRAM_LOADER_CHECKSUM_EN
    w = '{3'd3, 3'd5, 3'd6, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0};
    run_load(w, 3, 0, 1'b0);
    run_load(w, 3, 0, 1'b1);
    run_load(w, 0, 0, 1'b0);
`endif

    for (int k = 0; k < 10; k++) begin
      int n;
      n = CK ? int'($urandom_range(0, 8)) : int'($urandom_range(1, 8));
      for (int i = 0; i < 8; i++) w[i] = 3'($urandom_range(0, 7));
      run_load(w, n, 2, 1'($urandom_range(0, 3) == 0) && CK);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
